// File: rtl/rggen_register_access_initiator.sv
// rggen_register_access_initiator: host-side initiator that range-checks one request at a time,
// broadcasts it to the attached register blocks and returns their status/read data.
module rggen_register_access_initiator #(
    parameter int                       ADDRESS_WIDTH  = 8,
    parameter int                       BUS_WIDTH      = 32,
    parameter int                       REGISTERS      = 1,
    parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDRESS   = '0,
    parameter int                       BYTE_SIZE      = 256,
    parameter int                       TIMEOUT_CYCLES = 0
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_req_valid,
    output logic                           o_req_ready,
    input  logic [1:0]                     i_req_access,
    input  logic [ADDRESS_WIDTH-1:0]       i_req_address,
    input  logic [BUS_WIDTH-1:0]           i_req_write_data,
    input  logic [BUS_WIDTH-1:0]           i_req_strobe,
    output logic                           o_rsp_valid,
    input  logic                           i_rsp_ready,
    output logic [1:0]                     o_rsp_status,
    output logic [BUS_WIDTH-1:0]           o_rsp_read_data,
    output logic                           o_reg_valid,
    output logic [1:0]                     o_reg_access,
    output logic [ADDRESS_WIDTH-1:0]       o_reg_address,
    output logic [BUS_WIDTH-1:0]           o_reg_write_data,
    output logic [BUS_WIDTH-1:0]           o_reg_strobe,
    input  logic [REGISTERS-1:0]           i_reg_active,
    input  logic [REGISTERS-1:0]           i_reg_ready,
    input  logic [2*REGISTERS-1:0]         i_reg_status,
    input  logic [BUS_WIDTH*REGISTERS-1:0] i_reg_read_data
);
    localparam int LSB = $clog2(BUS_WIDTH / 8);
    localparam int CW  = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [ADDRESS_WIDTH-1:0] ADDRESS_MASK = {ADDRESS_WIDTH{1'b1}} << LSB;
    // One extra bit keeps the window end from wrapping at the top of the address space.
    localparam logic [ADDRESS_WIDTH:0] WINDOW_BASE = {1'b0, BASE_ADDRESS};
    localparam logic [ADDRESS_WIDTH:0] WINDOW_END  = WINDOW_BASE + (ADDRESS_WIDTH + 1)'(BYTE_SIZE);

    typedef enum logic [1:0] {IDLE, BUSY, RESPONSE} state_t;

    state_t                   state, state_next;
    logic [1:0]               access;
    logic [ADDRESS_WIDTH-1:0] address;
    logic [BUS_WIDTH-1:0]     write_data, strobe;
    logic [1:0]               status, status_next, mux_status;
    logic [BUS_WIDTH-1:0]     read_data, read_data_next, mux_data;
    logic [CW-1:0]            count, count_next;
    logic                     in_window, hit, done, expired, accept;

    assign in_window = {1'b0, i_req_address} >= WINDOW_BASE && {1'b0, i_req_address} < WINDOW_END;
    assign hit       = |i_reg_active;
    assign done      = hit && |(i_reg_active & i_reg_ready);
    assign expired   = TIMEOUT_CYCLES != 0 && int'(count) == TIMEOUT_CYCLES - 1;
    assign accept    = o_req_ready && i_req_valid;

    assign o_req_ready      = state == IDLE;
    assign o_reg_valid      = state == BUSY;
    assign o_rsp_valid      = state == RESPONSE;
    assign o_reg_access     = access;
    assign o_reg_address    = address;
    assign o_reg_write_data = write_data;
    assign o_reg_strobe     = strobe;
    assign o_rsp_status     = status;
    assign o_rsp_read_data  = read_data;

    always_comb begin
        mux_status = '0;
        mux_data   = '0;
        for (int i = 0; i < REGISTERS; i++) begin
            mux_status |= i_reg_active[i] ? i_reg_status[2*i+:2] : 2'd0;
            mux_data   |= i_reg_active[i] ? i_reg_read_data[BUS_WIDTH*i+:BUS_WIDTH] : '0;
        end
    end

    always_comb begin
        state_next     = state;
        status_next    = status;
        read_data_next = read_data;
        count_next     = count;
        case (state)
            IDLE: if (i_req_valid) begin
                state_next     = in_window ? BUSY : RESPONSE;
                status_next    = in_window ? 2'd0 : 2'd3;
                read_data_next = '0;
                count_next     = '0;
            end
            BUSY: if (!hit || done || expired) begin
                state_next     = RESPONSE;
                status_next    = !hit ? 2'd3 : done ? mux_status : 2'd2;
                read_data_next = (done && access == 2'b10) ? mux_data : '0;
            end else begin
                count_next = count + 1'b1;
            end
            RESPONSE: state_next = i_rsp_ready ? IDLE : RESPONSE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            status    <= '0;
            read_data <= '0;
            count     <= '0;
        end else begin
            state     <= state_next;
            status    <= status_next;
            read_data <= read_data_next;
            count     <= count_next;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            access     <= '0;
            address    <= '0;
            write_data <= '0;
            strobe     <= '0;
        end else if (accept) begin
            access     <= i_req_access;
            address    <= i_req_address & ADDRESS_MASK;
            write_data <= i_req_write_data;
            strobe     <= i_req_strobe;
        end
    end
endmodule

// File: tb/tb_rggen_register_access_initiator.sv
// tb_rggen_register_access_initiator: table of directed accesses against a two-register,
// 0x04..0x43 window with a 4-cycle timeout, plus handshake-overlap and mid-access reset sequences.
module tb_rggen_register_access_initiator;
    logic        clk = 0;
    logic        rst_n = 0;
    logic        req_valid = 0, req_ready, rsp_valid, rsp_ready = 0, reg_valid;
    logic [1:0]  req_access = 0, rsp_status, reg_access;
    logic [7:0]  req_address = 0, reg_address;
    logic [31:0] req_write_data = 0, req_strobe = 0, rsp_read_data, reg_write_data, reg_strobe;
    logic [1:0]  reg_active = 0, reg_ready = 0;
    logic [3:0]  reg_status = 0;
    logic [63:0] reg_read_data = 0;
    int          errors = 0, checks = 0;

    always #5 clk = ~clk;

    rggen_register_access_initiator #(
        .ADDRESS_WIDTH(8), .BUS_WIDTH(32), .REGISTERS(2),
        .BASE_ADDRESS(8'h04), .BYTE_SIZE(64), .TIMEOUT_CYCLES(4)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_access(req_access), .i_req_address(req_address),
        .i_req_write_data(req_write_data), .i_req_strobe(req_strobe),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
        .o_rsp_status(rsp_status), .o_rsp_read_data(rsp_read_data),
        .o_reg_valid(reg_valid), .o_reg_access(reg_access), .o_reg_address(reg_address),
        .o_reg_write_data(reg_write_data), .o_reg_strobe(reg_strobe),
        .i_reg_active(reg_active), .i_reg_ready(reg_ready),
        .i_reg_status(reg_status), .i_reg_read_data(reg_read_data)
    );

    typedef struct {
        logic [1:0]  acc;
        logic [7:0]  addr;
        logic [31:0] wd, strb;
        logic [1:0]  act, rdy;
        logic [3:0]  st;
        logic [63:0] rd;
        int          stall;
        int          exp_n;
        logic [1:0]  exp_st;
        logic [31:0] exp_rd;
        logic [7:0]  exp_addr;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        req_access = v.acc; req_address = v.addr; req_write_data = v.wd; req_strobe = v.strb;
        reg_active = v.act; reg_ready = v.rdy; reg_status = v.st; reg_read_data = v.rd;
    endtask

    task automatic run(input vec_t v, input int idx);
        int n = 0, k = 0;
        bit bad = 0;
        @(negedge clk);
        drive(v);
        req_valid = 1;
        chk($sformatf("v%0d req_ready_idle", idx), req_ready, 1);
        @(negedge clk);
        req_valid = 0;
        while (!rsp_valid && k < 20) begin
            if (reg_valid) begin
                n++;
                if ({reg_access, reg_address, reg_write_data, reg_strobe} !== {v.acc, v.exp_addr, v.wd, v.strb} || req_ready)
                    bad = 1;
            end
            @(negedge clk);
            k++;
        end
        chk($sformatf("v%0d rsp_valid_seen", idx), rsp_valid, 1);
        chk($sformatf("v%0d reg_valid_cycles", idx), n, v.exp_n);
        if (v.exp_n > 0) chk($sformatf("v%0d reg_fields", idx), bad, 0);
        chk($sformatf("v%0d rsp_status", idx), rsp_status, v.exp_st);
        chk($sformatf("v%0d rsp_read_data", idx), rsp_read_data, v.exp_rd);
        chk($sformatf("v%0d reg_valid_in_rsp", idx), reg_valid, 0);
        bad = 0;
        for (int c = 0; c < v.stall; c++) begin
            @(negedge clk);
            if (!rsp_valid || req_ready || reg_valid || rsp_status !== v.exp_st || rsp_read_data !== v.exp_rd) bad = 1;
        end
        if (v.stall > 0) chk($sformatf("v%0d rsp_stall_hold", idx), bad, 0);
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
        chk($sformatf("v%0d rsp_done", idx), rsp_valid, 0);
        chk($sformatf("v%0d req_ready_after", idx), req_ready, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        bit seen;
        vecs[0] = '{2'b10, 8'h04, 32'h0, 32'h0, 2'b10, 2'b10, 4'b0000, {32'hA5A5_0001, 32'h1234_5678}, 5, 1, 2'd0, 32'hA5A5_0001, 8'h04};
        vecs[1] = '{2'b11, 8'h08, 32'hDEAD_BEEF, 32'hFFFF_0000, 2'b01, 2'b01, 4'b0000, {32'h0, 32'h1111_1111}, 0, 1, 2'd0, 32'h0, 8'h08};
        vecs[2] = '{2'b10, 8'h44, 32'h0, 32'h0, 2'b01, 2'b01, 4'b0000, {32'h0, 32'h0000_0022}, 0, 0, 2'd3, 32'h0, 8'h44};
        vecs[3] = '{2'b10, 8'h03, 32'h0, 32'h0, 2'b01, 2'b01, 4'b0000, {32'h0, 32'h0000_0033}, 0, 0, 2'd3, 32'h0, 8'h00};
        vecs[4] = '{2'b10, 8'h20, 32'h0, 32'h0, 2'b00, 2'b11, 4'b0000, {32'h4444_4444, 32'h4444_4444}, 0, 1, 2'd3, 32'h0, 8'h20};
        vecs[5] = '{2'b10, 8'h43, 32'h0, 32'h0, 2'b01, 2'b01, 4'b0001, {32'hFFFF_FFFF, 32'hCAFE_F00D}, 0, 1, 2'd1, 32'hCAFE_F00D, 8'h40};
        vecs[6] = '{2'b01, 8'h10, 32'h1234_5678, 32'hFFFF_FFFF, 2'b10, 2'b10, 4'b1000, {32'h7777_7777, 32'h0}, 0, 1, 2'd2, 32'h0, 8'h10};
        vecs[7] = '{2'b10, 8'h0C, 32'h0, 32'h0, 2'b01, 2'b00, 4'b0000, {32'h0, 32'h0000_0099}, 2, 4, 2'd2, 32'h0, 8'h0C};
        vecs[8] = '{2'b10, 8'h14, 32'h0, 32'h0, 2'b11, 2'b01, 4'b0100, {32'h0000_00F0, 32'h0F00_0000}, 0, 1, 2'd1, 32'h0F00_00F0, 8'h14};
        vecs[9] = '{2'b11, 8'h42, 32'h0BAD_F00D, 32'h0000_FFFF, 2'b01, 2'b10, 4'b0000, {32'h0, 32'h0}, 0, 4, 2'd2, 32'h0, 8'h40};

        #1;
        chk("reset req_ready", req_ready, 1);
        chk("reset rsp_valid", rsp_valid, 0);
        chk("reset reg_valid", reg_valid, 0);
        chk("reset outputs", {rsp_status, rsp_read_data, reg_access, reg_address, reg_write_data, reg_strobe}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1;

        for (int i = 0; i < 10; i++) run(vecs[i], i);

        // A request held during the response handshake is taken one cycle later.
        @(negedge clk);
        drive(vecs[0]);
        req_valid = 1;
        @(negedge clk);
        k = 0;
        while (!rsp_valid && k < 10) begin @(negedge clk); k++; end
        chk("overlap rsp_valid", rsp_valid, 1);
        req_address = 8'h08;
        rsp_ready = 1;
        chk("overlap req_ready_in_handshake", req_ready, 0);
        @(negedge clk);
        rsp_ready = 0;
        chk("overlap not_accepted", {rsp_valid, reg_valid, req_ready}, 3'b001);
        @(negedge clk);
        req_valid = 0;
        chk("overlap accepted_next", reg_valid, 1);
        chk("overlap second_address", reg_address, 8'h08);
        @(negedge clk);
        chk("overlap second_rsp", {rsp_valid, rsp_status}, 3'b100);
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;

        // Reset in the middle of an access drops it without a response.
        drive(vecs[7]);
        req_valid = 1;
        @(negedge clk);
        req_valid = 0;
        @(negedge clk);
        chk("rst_mid busy", reg_valid, 1);
        rst_n = 0;
        #1;
        chk("rst_mid reg_valid", reg_valid, 0);
        chk("rst_mid req_ready", req_ready, 1);
        chk("rst_mid fields", {rsp_valid, rsp_status, reg_address}, 0);
        @(negedge clk);
        rst_n = 1;
        seen = 0;
        repeat (6) begin @(negedge clk); if (rsp_valid || reg_valid) seen = 1; end
        chk("rst_mid no_response", seen, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
